// File: rtl/sync_fifo_param.sv
// Parametrised synchronous FIFO with occupancy count, threshold flags and sticky error flags.
// Define SYNC_FIFO_FWFT_EN for a show-ahead (first-word-fall-through) read port.
module sync_fifo_param #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 6,
    parameter int AF_LEVEL = DEPTH - 1,
    parameter int AE_LEVEL = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    output logic                       full,
    input  logic                       rd_req,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       rd_valid,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int              CW      = $clog2(DEPTH + 1);
    localparam int              PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0]   DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0]   AF_C    = CW'(AF_LEVEL);
    localparam logic [CW-1:0]   AE_C    = CW'(AE_LEVEL);
    localparam logic            AF_RST  = (AF_LEVEL <= 0);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count_nxt;
    logic             pop_eff;
    logic             push_eff;

    // Explicit wrap so non-power-of-two depths never rely on modulo arithmetic.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        pop_eff  = rd_req && !empty;
        push_eff = wr_en && (!full || pop_eff);
        count_nxt = count;
        case ({push_eff, pop_eff})
            2'b10:   count_nxt = count + CW'(1);
            2'b01:   count_nxt = count - CW'(1);
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push_eff && !clear)
            mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            empty        <= 1'b1;
            full         <= 1'b0;
            almost_empty <= 1'b1;
            almost_full  <= AF_RST;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else if (clear) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            empty        <= 1'b1;
            full         <= 1'b0;
            almost_empty <= 1'b1;
            almost_full  <= AF_RST;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            if (push_eff)
                wr_ptr <= ptr_inc(wr_ptr);
            if (pop_eff)
                rd_ptr <= ptr_inc(rd_ptr);
            count        <= count_nxt;
            empty        <= (count_nxt == '0);
            full         <= (count_nxt == DEPTH_C);
            almost_empty <= (count_nxt <= AE_C);
            almost_full  <= (count_nxt >= AF_C);
            if (wr_en && full && !pop_eff)
                overflow <= 1'b1;
            if (rd_req && empty)
                underflow <= 1'b1;
        end
    end

`ifdef SYNC_FIFO_FWFT_EN
    // Head entry is shown ahead; gated to zero while empty so reset/clear read back as 0.
    always_comb begin
        rd_valid = !empty;
        rd_data  = empty ? '0 : mem[rd_ptr];
    end
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else if (clear) begin
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= pop_eff;
            if (pop_eff)
                rd_data <= mem[rd_ptr];
        end
    end
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench for sync_fifo_param (DEPTH=6, AF_LEVEL=4, AE_LEVEL=1); follows SYNC_FIFO_FWFT_EN if defined.
module tb_sync_fifo_param;

    logic       clk = 1'b0;
    logic       rst;
    logic       clear;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       full;
    logic       rd_req;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       empty;
    logic [2:0] count;
    logic       almost_full;
    logic       almost_empty;
    logic       overflow;
    logic       underflow;

    int passed = 0;
    int total  = 0;

    sync_fifo_param #(
        .WIDTH(8),
        .DEPTH(6),
        .AF_LEVEL(4),
        .AE_LEVEL(1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .clear(clear),
        .wr_en(wr_en),
        .wr_data(wr_data),
        .full(full),
        .rd_req(rd_req),
        .rd_data(rd_data),
        .rd_valid(rd_valid),
        .empty(empty),
        .count(count),
        .almost_full(almost_full),
        .almost_empty(almost_empty),
        .overflow(overflow),
        .underflow(underflow)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Called at a negedge; returns to the next negedge with wr_en low.
    task automatic push(input logic [7:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    // Single pop; samples the word the pop delivers in whichever read mode is built.
    task automatic do_pop(output logic [7:0] d, output logic v);
`ifdef SYNC_FIFO_FWFT_EN
        d = rd_data;
        v = rd_valid;
        rd_req = 1'b1;
        @(negedge clk);
        rd_req = 1'b0;
`else
        rd_req = 1'b1;
        @(negedge clk);
        rd_req = 1'b0;
        d = rd_data;
        v = rd_valid;
`endif
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; clear = 1'b0; wr_en = 1'b0; rd_req = 1'b0; wr_data = '0;
        #1;
        total++; if (empty !== 1'b1) $display("FAIL reset_empty: got %b want 1", empty); else passed++;
        total++; if (full !== 1'b0) $display("FAIL reset_full: got %b want 0", full); else passed++;
        total++; if (count !== 3'd0) $display("FAIL reset_count: got %0d want 0", count); else passed++;
        total++; if (almost_empty !== 1'b1) $display("FAIL reset_ae: got %b want 1", almost_empty); else passed++;
        total++; if (almost_full !== 1'b0) $display("FAIL reset_af: got %b want 0", almost_full); else passed++;
        total++; if (overflow !== 1'b0) $display("FAIL reset_ovf: got %b want 0", overflow); else passed++;
        total++; if (underflow !== 1'b0) $display("FAIL reset_udf: got %b want 0", underflow); else passed++;
        total++; if (rd_valid !== 1'b0) $display("FAIL reset_rd_valid: got %b want 0", rd_valid); else passed++;
        total++; if (rd_data !== 8'h00) $display("FAIL reset_rd_data: got %h want 00", rd_data); else passed++;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic();
        logic [7:0] exp [3] = '{8'hA1, 8'hB2, 8'hC3};
        logic [7:0] d;
        logic       v;
        for (int i = 0; i < 3; i++) push(exp[i]);
        total++; if (count !== 3'd3) $display("FAIL basic_count_full: got %0d want 3", count); else passed++;
        for (int i = 0; i < 3; i++) begin
            do_pop(d, v);
            total++; if (d !== exp[i]) $display("FAIL basic_data[%0d]: got %h want %h", i, d, exp[i]); else passed++;
            total++; if (v !== 1'b1) $display("FAIL basic_valid[%0d]: got %b want 1", i, v); else passed++;
            total++; if (count !== 3'(2 - i)) $display("FAIL basic_count[%0d]: got %0d want %0d", i, count, 2 - i); else passed++;
        end
        total++; if (empty !== 1'b1) $display("FAIL basic_empty: got %b want 1", empty); else passed++;
        @(negedge clk);
        total++; if (rd_valid !== 1'b0) $display("FAIL basic_valid_drop: got %b want 0", rd_valid); else passed++;
    endtask

    task automatic test_overflow();
        logic [7:0] d;
        logic       v;
        for (int i = 0; i < 6; i++) push(8'h10 + 8'(i));
        total++; if (full !== 1'b1) $display("FAIL ovf_full: got %b want 1", full); else passed++;
        total++; if (overflow !== 1'b0) $display("FAIL ovf_early: got %b want 0", overflow); else passed++;
        push(8'h16);
        total++; if (overflow !== 1'b1) $display("FAIL ovf_set: got %b want 1", overflow); else passed++;
        total++; if (count !== 3'd6) $display("FAIL ovf_count: got %0d want 6", count); else passed++;
        for (int i = 0; i < 6; i++) begin
            do_pop(d, v);
            total++; if (d !== 8'h10 + 8'(i)) $display("FAIL ovf_data[%0d]: got %h want %h", i, d, 8'h10 + 8'(i)); else passed++;
        end
        total++; if (empty !== 1'b1) $display("FAIL ovf_drained: got %b want 1", empty); else passed++;
        total++; if (overflow !== 1'b1) $display("FAIL ovf_sticky: got %b want 1", overflow); else passed++;
        do_clear();
        total++; if (overflow !== 1'b0) $display("FAIL ovf_clear: got %b want 0", overflow); else passed++;
    endtask

    task automatic test_wrap();
        logic [7:0] d;
        logic       v;
        for (int i = 0; i < 6; i++) push(8'h20 + 8'(i));
        for (int i = 0; i < 10; i++) begin
            wr_en = 1'b1; rd_req = 1'b1; wr_data = 8'h26 + 8'(i);
`ifdef SYNC_FIFO_FWFT_EN
            d = rd_data;
            @(negedge clk);
`else
            @(negedge clk);
            d = rd_data;
`endif
            total++; if (d !== 8'h20 + 8'(i)) $display("FAIL wrap_data[%0d]: got %h want %h", i, d, 8'h20 + 8'(i)); else passed++;
            total++; if (count !== 3'd6) $display("FAIL wrap_count[%0d]: got %0d want 6", i, count); else passed++;
        end
        wr_en = 1'b0; rd_req = 1'b0;
        total++; if (overflow !== 1'b0) $display("FAIL wrap_ovf: got %b want 0", overflow); else passed++;
        for (int i = 0; i < 6; i++) begin
            do_pop(d, v);
            total++; if (d !== 8'h2A + 8'(i)) $display("FAIL wrap_drain[%0d]: got %h want %h", i, d, 8'h2A + 8'(i)); else passed++;
        end
        total++; if (empty !== 1'b1) $display("FAIL wrap_empty: got %b want 1", empty); else passed++;
    endtask

    task automatic test_underflow_push();
        logic [7:0] d;
        logic       v;
        total++; if (underflow !== 1'b0) $display("FAIL udf_pre: got %b want 0", underflow); else passed++;
        wr_en = 1'b1; rd_req = 1'b1; wr_data = 8'h55;
        @(negedge clk);
        wr_en = 1'b0; rd_req = 1'b0;
        total++; if (underflow !== 1'b1) $display("FAIL udf_set: got %b want 1", underflow); else passed++;
        total++; if (count !== 3'd1) $display("FAIL udf_count: got %0d want 1", count); else passed++;
`ifndef SYNC_FIFO_FWFT_EN
        total++; if (rd_valid !== 1'b0) $display("FAIL udf_no_pop: got %b want 0", rd_valid); else passed++;
`endif
        do_pop(d, v);
        total++; if (d !== 8'h55) $display("FAIL udf_data: got %h want 55", d); else passed++;
        total++; if (v !== 1'b1) $display("FAIL udf_valid: got %b want 1", v); else passed++;
    endtask

    task automatic test_thresholds();
        logic [7:0] d;
        logic       v;
        total++; if (almost_empty !== 1'b1 || almost_full !== 1'b0)
            $display("FAIL thr_0: got ae=%b af=%b want ae=1 af=0", almost_empty, almost_full); else passed++;
        for (int k = 1; k <= 6; k++) begin
            push(8'h60 + 8'(k));
            total++; if (almost_empty !== (k <= 1) || almost_full !== (k >= 4))
                $display("FAIL thr_%0d: got ae=%b af=%b want ae=%b af=%b", k, almost_empty, almost_full, k <= 1, k >= 4);
            else passed++;
        end
        total++; if (full !== 1'b1) $display("FAIL thr_full: got %b want 1", full); else passed++;
        do_pop(d, v);
        total++; if (d !== 8'h61) $display("FAIL thr_pop: got %h want 61", d); else passed++;
        clear = 1'b1; wr_en = 1'b1; wr_data = 8'h99;
        @(negedge clk);
        clear = 1'b0; wr_en = 1'b0;
        total++; if (count !== 3'd0) $display("FAIL clr_count: got %0d want 0", count); else passed++;
        total++; if (empty !== 1'b1 || full !== 1'b0) $display("FAIL clr_empty_full: got e=%b f=%b want e=1 f=0", empty, full); else passed++;
        total++; if (almost_empty !== 1'b1 || almost_full !== 1'b0)
            $display("FAIL clr_thr: got ae=%b af=%b want ae=1 af=0", almost_empty, almost_full); else passed++;
        total++; if (underflow !== 1'b0) $display("FAIL clr_udf: got %b want 0", underflow); else passed++;
        total++; if (rd_valid !== 1'b0) $display("FAIL clr_valid: got %b want 0", rd_valid); else passed++;
`ifndef SYNC_FIFO_FWFT_EN
        total++; if (rd_data !== 8'h61) $display("FAIL clr_rd_data_hold: got %h want 61", rd_data); else passed++;
`endif
        @(negedge clk);
        total++; if (count !== 3'd0) $display("FAIL clr_write_ignored: got %0d want 0", count); else passed++;
    endtask

`ifdef SYNC_FIFO_FWFT_EN
    task automatic test_fwft();
        logic [7:0] d;
        logic       v;
        push(8'h3C);
        total++; if (rd_valid !== 1'b1) $display("FAIL fwft_valid: got %b want 1", rd_valid); else passed++;
        total++; if (rd_data !== 8'h3C) $display("FAIL fwft_data: got %h want 3C", rd_data); else passed++;
        do_pop(d, v);
        total++; if (empty !== 1'b1 || rd_valid !== 1'b0) $display("FAIL fwft_drain: got e=%b v=%b want e=1 v=0", empty, rd_valid); else passed++;
    endtask
`endif

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) push(8'h71 + 8'(i));
        rd_req = 1'b1;
        @(negedge clk);
        total++; if (rd_valid !== 1'b1) $display("FAIL rstmid_pre_valid: got %b want 1", rd_valid); else passed++;
        #2 rst = 1'b1;
        #1;
        total++; if (rd_valid !== 1'b0) $display("FAIL rstmid_valid: got %b want 0", rd_valid); else passed++;
        total++; if (count !== 3'd0 || empty !== 1'b1) $display("FAIL rstmid_count: got c=%0d e=%b want c=0 e=1", count, empty); else passed++;
        total++; if (rd_data !== 8'h00) $display("FAIL rstmid_data: got %h want 00", rd_data); else passed++;
        rd_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total++; if (empty !== 1'b1 || rd_valid !== 1'b0) $display("FAIL rstmid_after: got e=%b v=%b want e=1 v=0", empty, rd_valid); else passed++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_wrap();
        test_underflow_push();
        test_thresholds();
`ifdef SYNC_FIFO_FWFT_EN
        test_fwft();
`endif
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
